// File: rtl/sync_fifo_param_pkg.sv
// Shared constants for the parameterised synchronous FIFO: default geometry
// and the read-mode selectors used by the FWFT parameter.
package sync_fifo_param_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read gated by rd_en.
// No reset; the output register holds its value while rd_en is low.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // A read and write to the same address in one cycle returns the old word,
    // which is what a pop from a full FIFO with a concurrent push needs.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Synchronous FIFO with wrap-bit pointers, threshold flags, sticky error flags
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FWFT_OFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_req,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rdata_valid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] AF_LVL  = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_LVL  = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  out_valid_q, out_valid_d;
    logic                  seen_q, seen_d;

    logic                  mem_empty, mem_full, mem_pop, push_ok, consume, pop_err;
    logic                  head_valid;
    logic [ADDR_WIDTH:0]   mem_count;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // out_valid_q is the one-cycle read pulse in registered mode and the
    // head-occupied bit in FWFT mode; the RAM output register holds the head word.
    always_comb begin
        mem_empty = (wr_ptr_q == rd_ptr_q);
        mem_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        mem_count = wr_ptr_q - rd_ptr_q;

        if (FWFT == FWFT_ON) begin
            consume     = read_req && out_valid_q;
            mem_pop     = !mem_empty && (!out_valid_q || consume);
            pop_err     = read_req && !out_valid_q;
            out_valid_d = mem_pop || (out_valid_q && !consume);
        end else begin
            mem_pop     = read_req && !mem_empty;
            consume     = mem_pop;
            pop_err     = read_req && mem_empty;
            out_valid_d = mem_pop;
        end

        push_ok  = write_enable && (!mem_full || mem_pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = mem_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        seen_d   = seen_q || mem_pop;

        // A new error in the same cycle as clear_err keeps the flag set.
        ovf_d = (write_enable && !push_ok) ? 1'b1 : (clear_err ? 1'b0 : ovf_q);
        unf_d = pop_err ? 1'b1 : (clear_err ? 1'b0 : unf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            seen_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
            seen_q      <= seen_d;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (write_data),
        .rd_en   (mem_pop),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (ram_rdata)
    );

    // seen_q masks the unreset RAM output register until the first pop after reset.
    assign head_valid   = (FWFT == FWFT_ON) ? out_valid_q : 1'b0;
    assign fill_count   = mem_count + {{ADDR_WIDTH{1'b0}}, head_valid};
    assign fifo_empty   = (FWFT == FWFT_ON) ? !out_valid_q : mem_empty;
    assign fifo_full    = mem_full;
    assign almost_full  = (fill_count >= AF_LVL);
    assign almost_empty = (fill_count <= AE_LVL);
    assign read_data    = seen_q ? ram_rdata : '0;
    assign rdata_valid  = out_valid_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// checks both against reference models and expected-data queues.
module tb_sync_fifo_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          we, rr, clr;
    logic [DW-1:0] wd;

    logic [DW-1:0] read_data0, read_data1;
    logic          rdata_valid0, rdata_valid1;
    logic          fifo_empty0, fifo_empty1, fifo_full0, fifo_full1;
    logic          almost_empty0, almost_empty1, almost_full0, almost_full1;
    logic [AW:0]   fill_count0, fill_count1;
    logic          overflow0, overflow1, underflow0, underflow1;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .write_enable(we), .write_data(wd),
        .read_req(rr), .clear_err(clr), .read_data(read_data0),
        .rdata_valid(rdata_valid0), .fifo_empty(fifo_empty0), .fifo_full(fifo_full0),
        .almost_empty(almost_empty0), .almost_full(almost_full0),
        .fill_count(fill_count0), .overflow(overflow0), .underflow(underflow0)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .write_enable(we), .write_data(wd),
        .read_req(rr), .clear_err(clr), .read_data(read_data1),
        .rdata_valid(rdata_valid1), .fifo_empty(fifo_empty1), .fifo_full(fifo_full1),
        .almost_empty(almost_empty1), .almost_full(almost_full1),
        .fill_count(fill_count1), .overflow(overflow1), .underflow(underflow1)
    );

    // scoreboard and model state
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    int            cnt0, mc1;
    bit            pop0, ovf0, unf0, hv1, ovf1, unf1;
    logic [DW-1:0] last_rd0;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        cnt0 = 0; mc1 = 0;
        pop0 = 0; ovf0 = 0; unf0 = 0;
        hv1 = 0; ovf1 = 0; unf1 = 0;
        last_rd0 = '0;
    endtask

    task automatic check_flags();
        check_eq("cnt0",    fill_count0,   cnt0);
        check_eq("full0",   fifo_full0,    cnt0 == DEPTH);
        check_eq("empty0",  fifo_empty0,   cnt0 == 0);
        check_eq("af0",     almost_full0,  cnt0 >= AF);
        check_eq("ae0",     almost_empty0, cnt0 <= AE);
        check_eq("ovf0",    overflow0,     ovf0);
        check_eq("unf0",    underflow0,    unf0);
        check_eq("rvalid0", rdata_valid0,  pop0);
        if (pop0) last_rd0 = exp_q0.pop_front();
        check_eq("rdata0",  read_data0,    last_rd0);

        check_eq("cnt1",    fill_count1,   mc1 + hv1);
        check_eq("full1",   fifo_full1,    mc1 == DEPTH);
        check_eq("empty1",  fifo_empty1,   !hv1);
        check_eq("af1",     almost_full1,  (mc1 + hv1) >= AF);
        check_eq("ae1",     almost_empty1, (mc1 + hv1) <= AE);
        check_eq("ovf1",    overflow1,     ovf1);
        check_eq("unf1",    underflow1,    unf1);
        check_eq("rvalid1", rdata_valid1,  hv1);
        if (hv1) check_eq("rdata1", read_data1, exp_q1[0]);
    endtask

    // driver: one clock cycle of stimulus, model update, then post-edge checks
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        bit push, mpop, cons;
        we = w; wd = d; rr = r; clr = c;

        pop0 = r && (cnt0 > 0);
        push = w && ((cnt0 < DEPTH) || pop0);
        ovf0 = (w && !push) ? 1'b1 : (c ? 1'b0 : ovf0);
        unf0 = (r && cnt0 == 0) ? 1'b1 : (c ? 1'b0 : unf0);
        if (push) exp_q0.push_back(d);
        cnt0 = cnt0 + int'(push) - int'(pop0);

        cons = r && hv1;
        if (cons) void'(exp_q1.pop_front());
        mpop = (mc1 > 0) && (!hv1 || cons);
        push = w && ((mc1 < DEPTH) || mpop);
        ovf1 = (w && !push) ? 1'b1 : (c ? 1'b0 : ovf1);
        unf1 = (r && !hv1) ? 1'b1 : (c ? 1'b0 : unf1);
        if (push) exp_q1.push_back(d);
        mc1 = mc1 + int'(push) - int'(mpop);
        hv1 = mpop || (hv1 && !cons);

        @(posedge clk);
        #1;
        check_flags();
    endtask

    initial begin
        we = 0; wd = '0; rr = 0; clr = 0;
        model_reset();
        #2 rst = 1'b0;
        #1 check_flags();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // FWFT latency: single word visible two cycles after the push
        step(1, 32'h55, 0, 0);
        check_eq("fwft_lat_c1", rdata_valid1, 1'b0);
        step(0, '0, 0, 0);
        check_eq("fwft_lat_c2", rdata_valid1, 1'b1);
        check_eq("fwft_lat_data", read_data1, 32'h55);
        step(0, '0, 1, 0);
        check_eq("fwft_consumed", rdata_valid1, 1'b0);

        // fill to full and beyond, then drain past empty
        for (int i = 0; i < 18; i++) step(1, DW'(i), 0, 0);
        check_eq("full_cnt0", fill_count0, 16);
        check_eq("full_cnt1", fill_count1, 17);
        for (int i = 0; i < 18; i++) step(0, '0, 1, 0);
        check_eq("drain_unf0", underflow0, 1'b1);
        step(0, '0, 0, 1);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1, $urandom, 0, 0);
        step(1, 32'hAA, 1, 0);
        check_eq("simul_cnt0", fill_count0, 16);
        for (int i = 0; i < 17; i++) step(0, '0, 1, 0);
        check_eq("aa_last0", read_data0, 32'hAA);
        step(0, '0, 0, 1);

        // pointer wrap at constant occupancy
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 40; i++) step(1, $urandom, 1, 0);
        check_eq("wrap_cnt0", fill_count0, 3);
        for (int i = 0; i < 5; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);

        // random traffic, fill-biased then drain-biased
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
        for (int i = 0; i < 150; i++)
            step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);

        // asynchronous reset mid-operation with words stored and overflow set
        for (int i = 0; i < 20; i++) step(0, '0, 1, 0);
        step(0, '0, 0, 1);
        for (int i = 0; i < 18; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0);
        check_eq("pre_rst_cnt0", fill_count0, 9);
        check_eq("pre_rst_ovf0", overflow0, 1'b1);
        we = 0; rr = 0; clr = 0;
        #1 rst = 1'b0;
        #1 model_reset();
        check_flags();
        @(posedge clk);
        #1 rst = 1'b1;

        // stored words were discarded
        step(1, 32'h1234, 0, 0);
        step(1, 32'h5678, 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
